// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller
package uart_rx_pkg;

  localparam int RX_DATA_BITS = 8;
  localparam int RX_PS_W      = 6;

  localparam int RX_PS_8  = 8;
  localparam int RX_PS_16 = 16;
  localparam int RX_PS_32 = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_t;

  // States in which the edge/bit counters advance.
  function automatic logic in_frame(input rx_state_t s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and frame bit counter
module uart_rx_edge_bit_cnt #(
  parameter int PS_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic [PS_W-1:0] prescale,
  output logic [PS_W-1:0] edge_cnt,
  output logic [3:0]      bit_cnt,
  output logic            bit_end
);

  assign bit_end = (edge_cnt == (prescale - PS_W'(1)));

  // Dropping en clears both counters so every frame starts at edge 0 / bit 0.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = RX_DATA_BITS,
  parameter int PS_W      = RX_PS_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RX_IN,
  input  logic [PS_W-1:0] prescale,
  input  logic            PAR_EN,
  input  logic            strt_glitch,
  input  logic            par_err,
  input  logic            stp_err,
  output logic [PS_W-1:0] edge_cnt,
  output logic [3:0]      bit_cnt,
  output logic            dat_samp_en,
  output logic            deser_en,
  output logic            strt_chk_en,
  output logic            par_chk_en,
  output logic            stp_chk_en,
  output logic            data_valid,
  output logic            frame_err,
  output logic            parity_err
);

  rx_state_t state, next_state;
  logic      bit_end;
  logic      cnt_en;
  logic      par_en_q;
  logic      par_flag;
  logic      start_entry;
  logic      frame_err_d;
  logic      parity_err_d;

  // Counters only run while staying inside a frame; any entry or exit clears them.
  assign cnt_en = in_frame(state) && in_frame(next_state);

  uart_rx_edge_bit_cnt #(.PS_W(PS_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (cnt_en),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!RX_IN) next_state = ST_START;
      ST_START:  if (bit_end) next_state = strt_glitch ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt == 4'(DATA_BITS)))
                   next_state = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) next_state = ST_STOP;
      ST_STOP:   if (bit_end) next_state = (!stp_err && !par_flag) ? ST_DONE : ST_IDLE;
      ST_DONE:   next_state = RX_IN ? ST_IDLE : ST_START;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign start_entry  = (next_state == ST_START) && (state != ST_START);
  assign frame_err_d  = bit_end && (((state == ST_START) && strt_glitch) ||
                                    ((state == ST_STOP) && stp_err));
  assign parity_err_d = bit_end && (state == ST_PARITY) && par_err;

  // Parity mode and parity failure are frame-scoped; both reset at each new start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_q   <= 1'b0;
      par_flag   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_entry) begin
        par_en_q <= PAR_EN;
        par_flag <= 1'b0;
      end else if (parity_err_d) begin
        par_flag <= 1'b1;
      end
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
    end
  end

  assign dat_samp_en = (state != ST_IDLE);
  assign deser_en    = (state == ST_DATA);
  assign strt_chk_en = (state == ST_START);
  assign par_chk_en  = (state == ST_PARITY);
  assign stp_chk_en  = (state == ST_STOP);
  assign data_valid  = (state == ST_DONE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for the UART receive sequencer
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, parity_err;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .PAR_EN      (PAR_EN),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 CLK = ~CLK;

  // kind: 0 data_valid, 1 frame_err, 2 parity_err; delay counted from first START cycle
  typedef struct {
    int         kind;
    int         delay;
    int         deser;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int         cyc = 0, start_cyc = 0, deser_cyc = 0, latch_cnt = 0, last_valid = 0;
  logic [7:0] shreg = '0;
  bit         prev_strt = 1'b0;

  task automatic take(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_pulse_kind", k, -1);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", k, e.kind);
      chk("pulse_delay", cyc - start_cyc, e.delay);
      chk("deser_en_cycles", deser_cyc, e.deser);
      if (k == 0) begin
        chk("p_data", shreg, e.data);
        chk("deser_latches", latch_cnt, 8);
        if (e.gap > 0) chk("b2b_gap", cyc - last_valid, e.gap);
        last_valid = cyc;
      end
    end
  endtask

  // Deserializer model samples mid-bit, LSB first.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_strt = 1'b0;
    end else begin
      if (strt_chk_en && !prev_strt) begin
        start_cyc = cyc;
        deser_cyc = 0;
        latch_cnt = 0;
      end
      prev_strt = strt_chk_en;
      if (deser_en) begin
        deser_cyc++;
        if (edge_cnt == prescale / 2) shreg = {RX_IN, shreg[7:1]};
        if (edge_cnt == prescale - 6'd1) latch_cnt++;
      end
      if (data_valid) take(0);
      if (frame_err)  take(1);
      if (parity_err) take(2);
    end
  end

  task automatic push(input int k, input int dly, input int ds, input logic [7:0] d, input int gap);
    exp_t e;
    e.kind = k; e.delay = dly; e.deser = ds; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic drive_frame(input int ps, input bit par, input logic [7:0] d,
                             input bit g, input bit pe, input bit se, input int gap);
    int fl;
    prescale = 6'(ps); PAR_EN = par; strt_glitch = g; par_err = pe; stp_err = se;
    fl = (10 + int'(par)) * ps;
    if (g) begin
      push(1, ps, 0, 8'h00, 0);
    end else begin
      if (par && pe) push(2, 10 * ps, 8 * ps, 8'h00, 0);
      if (se)        push(1, fl, 8 * ps, 8'h00, 0);
      if (!(par && pe) && !se) push(0, fl, 8 * ps, d, gap);
    end
    RX_IN = 1'b0;
    if (g) begin
      hold(3);
      RX_IN = 1'b1;
      hold(ps);
    end else begin
      hold(ps);
      for (int i = 0; i < 8; i++) begin
        RX_IN = d[i];
        hold(ps);
      end
      if (par) begin
        RX_IN = ^d;
        hold(ps);
      end
      RX_IN = 1'b1;
      hold(ps);
    end
  endtask

  task automatic idle_check(input string tag);
    RX_IN = 1'b1;
    hold(8);
    chk(tag, {edge_cnt, bit_cnt, dat_samp_en}, 0);
  endtask

  initial begin
    RST = 1'b1;
    hold(3);
    chk("reset_outputs", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                          stp_chk_en, data_valid, frame_err, parity_err}, 0);
    RST = 1'b0;
    hold(2);

    drive_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
    idle_check("idle_after_a5");

    drive_frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 0);
    idle_check("idle_after_par_err");

    drive_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    idle_check("idle_after_par_ok");

    drive_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    idle_check("idle_after_glitch");

    drive_frame(32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
    idle_check("idle_after_stp_err");

    drive_frame(8, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1 + 10 * 8);
    idle_check("idle_after_b2b");

    // Reset in the middle of DATA, then a clean frame.
    prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    RX_IN = 1'b0;
    for (int i = 0; i < 200 && !(deser_en && bit_cnt == 4'd4); i++) hold(1);
    chk("reach_data_bit4", {deser_en, bit_cnt}, {1'b1, 4'd4});
    RST = 1'b1;
    RX_IN = 1'b1;
    hold(1);
    chk("midframe_reset_outputs", {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                   par_chk_en, stp_chk_en, data_valid, frame_err, parity_err}, 0);
    RST = 1'b0;
    hold(4);
    drive_frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 0);
    idle_check("idle_after_reset_frame");

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
